// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter and strobe sequencer for a 256x8 async-read RAM.
// Optional grant counters are compiled in when RAM_ARB_STATS_EN is defined.
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              n_cs,
  output logic              n_oe,
  output logic              n_we,
  output logic              busy,
  output logic              last_gnt
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                n_cs_q, n_cs_d;
  logic                n_oe_q, n_oe_d;
  logic                n_we_q, n_we_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                last_gnt_q, last_gnt_d;
  logic                winner;
  logic                win_we;

  // A tie goes to whoever was not served last; a lone request always wins.
  assign winner = (req0 && req1) ? ~last_gnt_q : req1;
  assign win_we = winner ? we1 : we0;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d    = state_q;
    n_cs_d     = 1'b1;
    n_oe_d     = 1'b1;
    n_we_d     = 1'b1;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    last_gnt_d = last_gnt_q;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          addr_d     = winner ? addr1 : addr0;
          wdata_d    = winner ? wdata1 : wdata0;
          n_cs_d     = 1'b0;
          n_oe_d     = win_we;
          n_we_d     = ~win_we;
          last_gnt_d = winner;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        // n_oe low marks a read; the RAM output is valid for this whole cycle.
        if (!n_oe_q) begin
          if (last_gnt_q) rdata1_d = ram_rdata;
          else            rdata0_d = ram_rdata;
        end
        gnt0_d  = ~last_gnt_q;
        gnt1_d  = last_gnt_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      n_cs_q     <= 1'b1;
      n_oe_q     <= 1'b1;
      n_we_q     <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      last_gnt_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q    <= state_d;
      n_cs_q     <= n_cs_d;
      n_oe_q     <= n_oe_d;
      n_we_q     <= n_we_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign ram_address = addr_q;
  assign ram_wdata   = wdata_q;
  assign n_cs        = n_cs_q;
  assign n_oe        = n_oe_q;
  assign n_we        = n_we_q;
  assign busy        = busy_q;
  assign last_gnt    = last_gnt_q;

`ifdef RAM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Counters advance on the same edge that raises gnt and stick at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt0_d && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (gnt1_d && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM256x8 model.
// Define RAM_ARB_STATS_EN at compile time to also exercise the grant counters.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic       gnt0, gnt1, n_cs, n_oe, n_we, busy, last_gnt;
  logic [7:0] rdata0, rdata1, ram_address, ram_wdata, ram_rdata;
`ifdef RAM_ARB_STATS_EN
  logic [1:0] gnt_cnt0, gnt_cnt1;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] mem [256];

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rdata1(rdata1),
    .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .n_cs(n_cs), .n_oe(n_oe), .n_we(n_we), .busy(busy), .last_gnt(last_gnt)
`ifdef RAM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!n_cs && !n_we) mem[ram_address] <= ram_wdata;
  end

  assign ram_rdata = (!n_cs && !n_oe) ? mem[ram_address] : 8'h00;

  always @(negedge clk) begin
    if (!n_oe && !n_we) begin
      fails++;
      $display("FAIL strobe_overlap: n_oe=%b n_we=%b required not both 0", n_oe, n_we);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // One access on port p; req raised in an IDLE cycle, dropped in the gnt cycle,
  // then one more cycle so the FSM is back in IDLE when the task returns.
  task automatic access(input bit p, input bit we, input logic [7:0] a, input logic [7:0] d,
                        output int lat, output int nwe_cyc, output bit other,
                        output logic [7:0] rd, output int busy_lows, output int gcyc);
    lat = 0; nwe_cyc = 0; other = 1'b0; busy_lows = 0; rd = 8'h00; gcyc = 0;
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    do begin
      tick();
      lat++;
      if (!n_we) nwe_cyc++;
      if (!busy) busy_lows++;
      if (p ? gnt0 : gnt1) other = 1'b1;
    end while (!(p ? gnt1 : gnt0) && lat < 20);
    if (lat >= 20) begin
      tests++; fails++;
      $display("FAIL access_timeout: port %0d no gnt after %0d cycles", p, lat);
    end
    rd   = p ? rdata1 : rdata0;
    gcyc = cyc;
    if (p) req1 = 1'b0; else req0 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({n_cs, n_oe, n_we} !== 3'b111) begin fails++;
      $display("FAIL reset_strobes: got %b expected 111", {n_cs, n_oe, n_we}); end
    tests++;
    if ({gnt0, gnt1, busy, last_gnt} !== 4'b0001) begin fails++;
      $display("FAIL reset_flags: gnt0,gnt1,busy,last_gnt got %b expected 0001", {gnt0, gnt1, busy, last_gnt}); end
    tests++;
    if ({rdata0, rdata1, ram_address, ram_wdata} !== 32'h0) begin fails++;
      $display("FAIL reset_data: got %h expected 00000000", {rdata0, rdata1, ram_address, ram_wdata}); end
  endtask

  task automatic test_write_read();
    int lat, nwe, bl, gc;
    bit other;
    logic [7:0] rd;
    do_reset();
    access(1'b0, 1'b1, 8'h10, 8'hA5, lat, nwe, other, rd, bl, gc);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    tests++;
    if (nwe !== 1) begin fails++; $display("FAIL wr_nwe_cycles: got %0d expected 1", nwe); end
    tests++;
    if (mem[8'h10] !== 8'hA5) begin fails++; $display("FAIL wr_commit: got %h expected a5", mem[8'h10]); end
    access(1'b0, 1'b0, 8'h10, 8'h00, lat, nwe, other, rd, bl, gc);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    tests++;
    if (rd !== 8'hA5) begin fails++; $display("FAIL rd_data: got %h expected a5", rd); end
    tests++;
    if (nwe !== 0 || other) begin fails++;
      $display("FAIL rd_side: n_we cycles %0d gnt1 seen %0d expected 0 0", nwe, other); end
  endtask

  task automatic test_addr_bounds();
    int lat, nwe, bl, gc;
    bit other;
    logic [7:0] rd;
    access(1'b1, 1'b1, 8'h00, 8'h11, lat, nwe, other, rd, bl, gc);
    access(1'b1, 1'b1, 8'hFF, 8'hEE, lat, nwe, other, rd, bl, gc);
    access(1'b1, 1'b0, 8'h00, 8'h00, lat, nwe, other, rd, bl, gc);
    tests++;
    if (rd !== 8'h11) begin fails++; $display("FAIL addr_00: got %h expected 11", rd); end
    access(1'b1, 1'b0, 8'hFF, 8'h00, lat, nwe, other, rd, bl, gc);
    tests++;
    if (rd !== 8'hEE || rdata0 !== 8'hA5) begin fails++;
      $display("FAIL addr_ff: rdata1 %h rdata0 %h expected ee a5", rd, rdata0); end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin tick(); n++; end while (!(gnt0 || gnt1) && n < 10);
      tests++;
      if ({gnt0, gnt1} !== ((g % 2 == 0) ? 2'b10 : 2'b01) || last_gnt !== 1'(g % 2)) begin fails++;
        $display("FAIL rr_order%0d: gnt0,gnt1 %b last_gnt %b expected grant to %0d", g, {gnt0, gnt1}, last_gnt, g % 2); end
      tests++;
      if (n !== ((g == 0) ? 2 : 3)) begin fails++;
        $display("FAIL rr_spacing%0d: got %0d cycles expected %0d", g, n, (g == 0) ? 2 : 3); end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    tests++;
    if (rdata0 !== 8'hA5 || rdata1 !== 8'hEE) begin fails++;
      $display("FAIL rr_rdata: got %h %h expected a5 ee", rdata0, rdata1); end
  endtask

  task automatic test_back_to_back();
    int lat, nwe, bl, gc, prev;
    bit other;
    logic [7:0] rd;
    do_reset();
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b0, 8'h10, 8'h00, lat, nwe, other, rd, bl, gc);
      tests++;
      if (lat !== 2 || rd !== 8'hA5 || other || bl !== 0) begin fails++;
        $display("FAIL stream%0d: lat %0d rd %h gnt0 %0d busy_low %0d expected 2 a5 0 0", i, lat, rd, other, bl); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL stream_idle%0d: busy %b expected 0", i, busy); end
      if (i > 0) begin
        tests++;
        if (gc - prev !== 3) begin fails++; $display("FAIL stream_period%0d: got %0d expected 3", i, gc - prev); end
      end
      prev = gc;
    end
  endtask

  task automatic test_reset_mid_write();
    int lat, nwe, bl, gc;
    bit other;
    logic [7:0] rd;
    bit seen;
    do_reset();
    access(1'b1, 1'b1, 8'h20, 8'h00, lat, nwe, other, rd, bl, gc);
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h3C;
    tick();
    tests++;
    if (n_we !== 1'b0 || ram_address !== 8'h20) begin fails++;
      $display("FAIL rst_wr_access: n_we %b addr %h expected 0 20", n_we, ram_address); end
    reset = 1'b1;
    tick();
    req1 = 1'b0;
    tests++;
    if (mem[8'h20] !== 8'h3C) begin fails++; $display("FAIL rst_wr_commit: got %h expected 3c", mem[8'h20]); end
    tests++;
    if ({n_cs, n_oe, n_we, busy, last_gnt, gnt1} !== 6'b111010) begin fails++;
      $display("FAIL rst_wr_outputs: n_cs,n_oe,n_we,busy,last_gnt,gnt1 got %b expected 111010", {n_cs, n_oe, n_we, busy, last_gnt, gnt1}); end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); if (gnt1 || gnt0) seen = 1'b1; end
    tests++;
    if (seen) begin fails++; $display("FAIL rst_wr_no_gnt: gnt after reset got 1 expected 0"); end
  endtask

  task automatic test_input_change();
    int lat, nwe, bl, gc;
    bit other;
    logic [7:0] rd;
    do_reset();
    access(1'b1, 1'b1, 8'h05, 8'h5A, lat, nwe, other, rd, bl, gc);
    access(1'b1, 1'b1, 8'h06, 8'h66, lat, nwe, other, rd, bl, gc);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    tick();
    addr0 = 8'h06;
    we0 = 1'b1;
    tests++;
    if (ram_address !== 8'h05 || n_oe !== 1'b0) begin fails++;
      $display("FAIL chg_addr: addr %h n_oe %b expected 05 0", ram_address, n_oe); end
    tick();
    tests++;
    if (gnt0 !== 1'b1 || rdata0 !== 8'h5A) begin fails++;
      $display("FAIL chg_rdata: gnt0 %b rdata0 %h expected 1 5a", gnt0, rdata0); end
    req0 = 1'b0; we0 = 1'b0;
    tick();
    tests++;
    if (mem[8'h06] !== 8'h66) begin fails++; $display("FAIL chg_no_write: mem[06] %h expected 66", mem[8'h06]); end
  endtask

`ifdef RAM_ARB_STATS_EN
  task automatic test_stats();
    int lat, nwe, bl, gc;
    bit other;
    logic [7:0] rd;
    logic [1:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      access(1'b0, 1'b0, 8'h10, 8'h00, lat, nwe, other, rd, bl, gc);
      exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
      tests++;
      if (gnt_cnt0 !== exp_cnt || gnt_cnt1 !== 2'd0) begin fails++;
        $display("FAIL stats%0d: cnt0 %0d cnt1 %0d expected %0d 0", i, gnt_cnt0, gnt_cnt1, exp_cnt); end
    end
    do_reset();
    tests++;
    if (gnt_cnt0 !== 2'd0 || gnt_cnt1 !== 2'd0) begin fails++;
      $display("FAIL stats_reset: cnt0 %0d cnt1 %0d expected 0 0", gnt_cnt0, gnt_cnt1); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_addr_bounds();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_write();
    test_input_change();
`ifdef RAM_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Two-requester arbiter and access sequencer for the shared RAM256x8 (256x8, active-low n_cs/n_oe/n_we, write on posedge clk, combinational read).
- Requester 0 is the CPU datapath memory path (load/store). Requester 1 is the program/data loader.
- The block serialises single-byte accesses through a req/gnt handshake with round-robin fairness and drives the RAM control strobes from registers.
- The top level drives the bidirectional RAM data bus from ram_wdata only while n_cs=0, n_oe=1, n_we=0.

Parameters:
ADDR_W, 8, address width; RAM depth is 2**ADDR_W.
DATA_W, 8, data width.
CNT_W, 8, width of the grant counters (only with the optional feature).

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
req0  in  1  requester 0 access request; held until gnt0
we0  in  1  requester 0: 1 = write, 0 = read
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  one-cycle pulse: requester 0 access completed
rdata0  out  DATA_W  requester 0 read data; valid when gnt0=1 and the access was a read
req1, we1, addr1, wdata1, gnt1, rdata1: same as above for requester 1
ram_address  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  data to drive onto the RAM bus during writes
ram_rdata  in  DATA_W  RAM bus value sampled on reads
n_cs  out  1  RAM chip select, active low
n_oe  out  1  RAM output enable, active low
n_we  out  1  RAM write enable, active low
busy  out  1  1 while state is not IDLE
last_gnt  out  1  index of the most recently granted requester

Behaviour:
- Reset values (at the edge where reset=1): state=IDLE, n_cs=n_oe=n_we=1, gnt0=gnt1=0, rdata0=rdata1=0, ram_address=0, ram_wdata=0, busy=0, last_gnt=1.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any req is 1, choose the winner and latch its we/addr/wdata into ram_address/ram_wdata.
  - Strobes for ACCESS: read gives n_cs=0, n_oe=0, n_we=1; write gives n_cs=0, n_oe=1, n_we=0.
  - Set last_gnt=winner, go to ACCESS.
  - If no req is 1, stay in IDLE with strobes at 1.
- Arbitration: if only one req is 1, it wins. If both are 1, the winner is the requester not equal to last_gnt. After reset, requester 0 wins the first tie.
- ACCESS (exactly 1 cycle):
  - Strobes are active for the whole cycle. A write commits in the RAM at the edge ending ACCESS.
  - On a read, ram_rdata is sampled at that edge into the winner's rdata register.
  - At that edge, strobes return to 1, the winner's gnt is set to 1, and the state goes to DONE.
- DONE (1 cycle): gnt of the winner is 1. At the edge ending DONE, gnt returns to 0 and the state goes to IDLE.
- The loser's gnt stays 0 throughout.
- Latency: a req first sampled at edge E in IDLE produces gnt=1 in the cycle after edge E+1, i.e. 2 cycles. Back-to-back throughput is one access per 3 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Drop req in the cycle gnt is high. A req still high in IDLE after DONE is treated as a new request.
- rdata0 and rdata1 hold their last read value until the next read for that requester. Writes do not modify rdata.
- Request inputs changing during ACCESS/DONE are ignored because the access uses latched values.
- Reset mid-operation:
  - A write with active strobes at the reset edge is committed by the RAM at that edge.
  - From the next cycle, all outputs take reset values and no gnt is issued for the aborted access.
- ram_address wraps naturally; there is no range check, and addresses 0 and 255 are legal.
- The arbiter never asserts n_oe=0 and n_we=0 in the same cycle.

Optional Feature:
RAM_ARB_STATS_EN:
- Defined: adds outputs gnt_cnt0 and gnt_cnt1 (out, CNT_W bits).
  - Each counter increments by 1 on every gnt pulse of its requester and saturates at 2**CNT_W-1; there is no wrap.
  - Both counters clear to 0 on reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Write then read on requester 0: req0=1, we0=1, addr0=0x10, wdata0=0xA5, then req0=1, we0=0, addr0=0x10 -> n_we=0 for exactly 1 cycle; gnt0 pulses 2 cycles after each req sampling; rdata0=0xA5 on the second gnt0; gnt1 stays 0.
2. Simultaneous requests after reset: req0=req1=1 held, both reads -> grants ordered 0,1,0,1; last_gnt toggles each grant; the requester not granted never sees gnt.
3. Single requester streaming: req1 re-asserted in IDLE after each gnt1, for 4 accesses -> gnt1 every 3 cycles; busy=0 for exactly 1 cycle between accesses; requester 0 idle.
4. Reset during a write ACCESS cycle (addr1=0x20, wdata1=0x3C) -> RAM[0x20]=0x3C; gnt1 never pulses; next cycle n_cs=n_oe=n_we=1, busy=0, last_gnt=1.
5. Input change mid-access: addr0 changed from 0x05 to 0x06 during ACCESS -> ram_address stays 0x05; rdata0 = RAM[0x05].
6. RAM_ARB_STATS_EN defined, CNT_W=2, 5 grants to requester 0 -> gnt_cnt0 = 1, 2, 3, 3, 3; gnt_cnt1 = 0; reset clears both to 0.
